// File: rtl/rvh_l1d_ld_split_align_if.sv
// Handshake bundle between the LSU load pipe, the L1D bank port and the load-result path.
// The slave modport is the split/align block's view; master is the surrounding pipe.
interface rvh_l1d_ld_split_align_if #(
    parameter int LINE_BYTES = 64,
    parameter int OFFSET_W   = $clog2(LINE_BYTES),
    parameter int PADDR_W    = 56,
    parameter int XLEN       = 64,
    parameter int TAG_W      = 8
);
    logic                         ld_req_vld_i;
    logic                         ld_req_rdy_o;
    logic [2:0]                   ld_req_op_i;
    logic [PADDR_W-1:0]           ld_req_paddr_i;
    logic [TAG_W-1:0]             ld_req_tag_i;
    logic                         l1d_req_vld_o;
    logic                         l1d_req_rdy_i;
    logic [PADDR_W-OFFSET_W-1:0]  l1d_req_line_o;
    logic [LINE_BYTES-1:0]        l1d_req_mask_o;
    logic                         l1d_resp_vld_i;
    logic [LINE_BYTES*8-1:0]      l1d_resp_data_i;
    logic                         ld_resp_vld_o;
    logic                         ld_resp_rdy_i;
    logic [XLEN-1:0]              ld_resp_data_o;
    logic [TAG_W-1:0]             ld_resp_tag_o;
    logic                         ld_resp_err_o;
    logic                         flush_i;

    modport slave (
        input  ld_req_vld_i, ld_req_op_i, ld_req_paddr_i, ld_req_tag_i,
        output ld_req_rdy_o,
        output l1d_req_vld_o, l1d_req_line_o, l1d_req_mask_o,
        input  l1d_req_rdy_i,
        input  l1d_resp_vld_i, l1d_resp_data_i,
        output ld_resp_vld_o, ld_resp_data_o, ld_resp_tag_o, ld_resp_err_o,
        input  ld_resp_rdy_i,
        input  flush_i
    );

    modport master (
        output ld_req_vld_i, ld_req_op_i, ld_req_paddr_i, ld_req_tag_i,
        input  ld_req_rdy_o,
        input  l1d_req_vld_o, l1d_req_line_o, l1d_req_mask_o,
        output l1d_req_rdy_i,
        output l1d_resp_vld_i, l1d_resp_data_i,
        input  ld_resp_vld_o, ld_resp_data_o, ld_resp_tag_o, ld_resp_err_o,
        output ld_resp_rdy_i,
        output flush_i
    );
endinterface

// File: rtl/rvh_l1d_ld_split_align.sv
// Load mask generation, line-crossing split, byte merge and sign/zero extension.
// Latency: result valid 3 cycles after accept (5 when split) with a ready L1D answering next cycle.
// Backpressure: one load in flight; request ready only in IDLE, result held until consumed.
module rvh_l1d_ld_split_align #(
    parameter int LINE_BYTES = 64,
    parameter int OFFSET_W   = $clog2(LINE_BYTES),
    parameter int PADDR_W    = 56,
    parameter int XLEN       = 64,
    parameter int TAG_W      = 8
) (
    input logic                       clk,
    input logic                       rst,
    rvh_l1d_ld_split_align_if.slave   io
);
    localparam int LINE_W = PADDR_W - OFFSET_W;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP, DRAIN} state_e;

    state_e              state_q, state_d;
    logic                rdy_q, rdy_d;
    logic                l1d_vld_q, l1d_vld_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [LINE_BYTES-1:0] mask_q, mask_d;
    logic                resp_vld_q, resp_vld_d;
    logic [XLEN-1:0]     resp_data_q, resp_data_d;
    logic [TAG_W-1:0]    resp_tag_q, resp_tag_d;
    logic                resp_err_q, resp_err_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [OFFSET_W-1:0] off_q, off_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [63:0]         acc_q, acc_d;

    function automatic logic [7:0] low_mask(input logic [3:0] n);
        return 8'((9'd1 << n) - 9'd1);
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [63:0] raw, input logic [1:0] sz,
                                               input logic uns);
        logic            sign;
        logic [XLEN-1:0] r;
        case (sz)
            2'd0:    sign = raw[7];
            2'd1:    sign = raw[15];
            2'd2:    sign = raw[31];
            default: sign = raw[63];
        endcase
        sign = sign & ~uns;
        r = '0;
        for (int i = 0; i < XLEN / 8; i++) begin
            r[i*8 +: 8] = (i < (1 << sz)) ? raw[(i % 8)*8 +: 8] : {8{sign}};
        end
        return r;
    endfunction

    logic [3:0]            req_bytes;
    logic [OFFSET_W-1:0]   req_off;
    logic [LINE_BYTES-1:0] req_mask;
    logic [3:0]            cur_bytes;
    logic [OFFSET_W:0]     end_off;
    logic                  split;
    logic [2:0]            p1_cnt;
    logic [2:0]            n0_lo;
    logic [63:0]           part0, part1, raw;

    assign req_bytes = 4'd1 << io.ld_req_op_i[1:0];
    assign req_off   = io.ld_req_paddr_i[OFFSET_W-1:0];
    // Bytes shifted past the top of the line fall off, which is exactly part 0 of a split.
    assign req_mask  = LINE_BYTES'(low_mask(req_bytes)) << req_off;

    assign cur_bytes = 4'd1 << size_q;
    assign end_off   = {1'b0, off_q} + (OFFSET_W+1)'(cur_bytes);
    assign split     = end_off[OFFSET_W] && (end_off[OFFSET_W-1:0] != '0);
    // A split spills at most 7 bytes, so the low three bits carry both part sizes.
    assign p1_cnt    = end_off[2:0];
    assign n0_lo     = 3'd0 - off_q[2:0];

    assign part0 = 64'(io.l1d_resp_data_i >> {off_q, 3'b000});
    assign part1 = 64'(io.l1d_resp_data_i) << {n0_lo, 3'b000};
    assign raw   = (state_q == WAIT1) ? (acc_q | part1) : part0;

    always_comb begin
        state_d     = state_q;
        rdy_d       = rdy_q;
        l1d_vld_d   = l1d_vld_q;
        line_d      = line_q;
        mask_d      = mask_q;
        resp_vld_d  = resp_vld_q;
        resp_data_d = resp_data_q;
        resp_tag_d  = resp_tag_q;
        resp_err_d  = resp_err_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        tag_d       = tag_q;
        acc_d       = acc_q;
        case (state_q)
            IDLE: begin
                if (io.ld_req_vld_i && !io.flush_i) begin
                    rdy_d  = 1'b0;
                    size_d = io.ld_req_op_i[1:0];
                    uns_d  = io.ld_req_op_i[2];
                    off_d  = req_off;
                    tag_d  = io.ld_req_tag_i;
                    if (io.ld_req_op_i == 3'd7) begin
                        state_d     = RESP;
                        resp_vld_d  = 1'b1;
                        resp_data_d = '0;
                        resp_tag_d  = io.ld_req_tag_i;
                        resp_err_d  = 1'b1;
                    end else begin
                        state_d   = REQ0;
                        l1d_vld_d = 1'b1;
                        line_d    = io.ld_req_paddr_i[PADDR_W-1:OFFSET_W];
                        mask_d    = req_mask;
                    end
                end
            end
            REQ0, REQ1: begin
                if (io.flush_i) begin
                    state_d   = IDLE;
                    l1d_vld_d = 1'b0;
                    rdy_d     = 1'b1;
                end else if (io.l1d_req_rdy_i) begin
                    state_d   = (state_q == REQ0) ? WAIT0 : WAIT1;
                    l1d_vld_d = 1'b0;
                end
            end
            WAIT0, WAIT1: begin
                // A response arriving with the flush is the one being killed, so skip DRAIN.
                if (io.flush_i) begin
                    state_d = io.l1d_resp_vld_i ? IDLE : DRAIN;
                    rdy_d   = io.l1d_resp_vld_i;
                end else if (io.l1d_resp_vld_i) begin
                    if (state_q == WAIT0 && split) begin
                        state_d   = REQ1;
                        acc_d     = part0;
                        l1d_vld_d = 1'b1;
                        line_d    = line_q + LINE_W'(1);
                        mask_d    = LINE_BYTES'(low_mask({1'b0, p1_cnt}));
                    end else begin
                        state_d     = RESP;
                        resp_vld_d  = 1'b1;
                        resp_data_d = extend(raw, size_q, uns_q);
                        resp_tag_d  = tag_q;
                        resp_err_d  = 1'b0;
                    end
                end
            end
            RESP: begin
                if (io.flush_i || io.ld_resp_rdy_i) begin
                    state_d    = IDLE;
                    resp_vld_d = 1'b0;
                    rdy_d      = 1'b1;
                end
            end
            DRAIN: begin
                if (io.l1d_resp_vld_i) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                rdy_d      = 1'b1;
                l1d_vld_d  = 1'b0;
                resp_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b1;
            l1d_vld_q   <= 1'b0;
            line_q      <= '0;
            mask_q      <= '0;
            resp_vld_q  <= 1'b0;
            resp_data_q <= '0;
            resp_tag_q  <= '0;
            resp_err_q  <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            tag_q       <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            l1d_vld_q   <= l1d_vld_d;
            line_q      <= line_d;
            mask_q      <= mask_d;
            resp_vld_q  <= resp_vld_d;
            resp_data_q <= resp_data_d;
            resp_tag_q  <= resp_tag_d;
            resp_err_q  <= resp_err_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            tag_q       <= tag_d;
            acc_q       <= acc_d;
        end
    end

    assign io.ld_req_rdy_o   = rdy_q;
    assign io.l1d_req_vld_o  = l1d_vld_q;
    assign io.l1d_req_line_o = line_q;
    assign io.l1d_req_mask_o = mask_q;
    assign io.ld_resp_vld_o  = resp_vld_q;
    assign io.ld_resp_data_o = resp_data_q;
    assign io.ld_resp_tag_o  = resp_tag_q;
    assign io.ld_resp_err_o  = resp_err_q;
endmodule

// File: tb/tb_rvh_l1d_ld_split_align.sv
// Directed loads against a small line memory; expected results and L1D accesses are queued
// by the stimulus and checked by independent monitor/responder processes.
module tb_rvh_l1d_ld_split_align;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rvh_l1d_ld_split_align_if bus ();
    rvh_l1d_ld_split_align dut (.clk(clk), .rst(rst), .io(bus));

    typedef struct {
        logic [63:0] data;
        logic [7:0]  tag;
        logic        err;
        int          lat;
    } resp_t;
    typedef struct {
        logic [49:0] line;
        logic [63:0] mask;
    } l1d_t;

    resp_t       sb_q[$];
    l1d_t        l1q[$];
    logic [511:0] mem [logic [49:0]];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int resp_dly = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    task automatic set_byte(input logic [49:0] ln, input int idx, input logic [7:0] v);
        logic [511:0] t;
        t = mem.exists(ln) ? mem[ln] : '0;
        t[idx*8 +: 8] = v;
        mem[ln] = t;
    endtask

    task automatic exp_l1d(input logic [49:0] ln, input logic [63:0] m);
        l1d_t e;
        e.line = ln;
        e.mask = m;
        l1q.push_back(e);
    endtask

    task automatic exp_resp(input logic [63:0] d, input logic [7:0] t, input logic er, input int lat);
        resp_t e;
        e.data = d;
        e.tag  = t;
        e.err  = er;
        e.lat  = lat;
        sb_q.push_back(e);
    endtask

    task automatic send(input logic [2:0] op, input logic [55:0] pa, input logic [7:0] tag);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        bus.ld_req_vld_i   = 1'b1;
        bus.ld_req_op_i    = op;
        bus.ld_req_paddr_i = pa;
        bus.ld_req_tag_i   = tag;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ld_req_rdy_o) begin
                acc_cyc = cyc;
                ok = 1;
                break;
            end
        end
        if (!ok) fail_evt("req_accept_timeout");
        @(posedge clk);
        #1 bus.ld_req_vld_i = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && l1q.size() == 0 && bus.ld_resp_vld_o == 1'b0 && bus.ld_req_rdy_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_evt("drain_timeout");
    endtask

    // Result monitor
    initial begin
        resp_t e;
        logic prev_vld;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.ld_resp_vld_o && !prev_vld && sb_q.size() > 0 && sb_q[0].lat >= 0)
                    chk("latency", 64'(cyc - acc_cyc), 64'(sb_q[0].lat));
                if (bus.ld_resp_vld_o && bus.ld_resp_rdy_i) begin
                    if (sb_q.size() == 0) fail_evt("unexpected_ld_resp");
                    else begin
                        e = sb_q.pop_front();
                        chk("resp_data", bus.ld_resp_data_o, e.data);
                        chk("resp_tag", 64'(bus.ld_resp_tag_o), 64'(e.tag));
                        chk("resp_err", 64'(bus.ld_resp_err_o), 64'(e.err));
                    end
                end
            end
            prev_vld = bus.ld_resp_vld_o;
        end
    end

    // L1D responder: checks each accepted access, returns the line resp_dly cycles later
    initial begin
        l1d_t        x;
        logic [49:0] ln;
        bus.l1d_resp_vld_i  = 1'b0;
        bus.l1d_resp_data_i = '0;
        forever begin
            @(negedge clk);
            if (rst && bus.l1d_req_vld_o && bus.l1d_req_rdy_i) begin
                ln = bus.l1d_req_line_o;
                if (l1q.size() == 0) fail_evt("unexpected_l1d_req");
                else begin
                    x = l1q.pop_front();
                    chk("l1d_line", 64'(ln), 64'(x.line));
                    chk("l1d_mask", bus.l1d_req_mask_o, x.mask);
                end
                @(posedge clk);
                repeat (resp_dly - 1) @(posedge clk);
                #1;
                bus.l1d_resp_vld_i  = 1'b1;
                bus.l1d_resp_data_i = mem.exists(ln) ? mem[ln] : '0;
                @(posedge clk);
                #1 bus.l1d_resp_vld_i = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hs;
        rst = 1'b0;
        bus.ld_req_vld_i   = 1'b0;
        bus.ld_req_op_i    = '0;
        bus.ld_req_paddr_i = '0;
        bus.ld_req_tag_i   = '0;
        bus.l1d_req_rdy_i  = 1'b1;
        bus.ld_resp_rdy_i  = 1'b1;
        bus.flush_i        = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", 64'(bus.ld_req_rdy_o), 64'd1);
        chk("rst_l1d_vld", 64'(bus.l1d_req_vld_o), 64'd0);
        chk("rst_resp_vld", 64'(bus.ld_resp_vld_o), 64'd0);
        chk("rst_mask", bus.l1d_req_mask_o, 64'd0);
        chk("rst_line", 64'(bus.l1d_req_line_o), 64'd0);
        chk("rst_data", bus.ld_resp_data_o, 64'd0);
        chk("rst_tag_err", 64'({bus.ld_resp_tag_o, bus.ld_resp_err_o}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // LW aligned, signed
        set_byte(50'h40, 7, 8'h80);
        exp_l1d(50'h40, 64'h0000_0000_0000_00F0);
        exp_resp(64'hFFFF_FFFF_8000_0000, 8'h11, 1'b0, 3);
        send(3'd2, 56'h1004, 8'h11);
        wait_done();

        // LD crossing into the next line
        set_byte(50'h800, 60, 8'h11); set_byte(50'h800, 61, 8'h22);
        set_byte(50'h800, 62, 8'h33); set_byte(50'h800, 63, 8'h44);
        set_byte(50'h801, 0, 8'h55);  set_byte(50'h801, 1, 8'h66);
        set_byte(50'h801, 2, 8'h77);  set_byte(50'h801, 3, 8'h88);
        exp_l1d(50'h800, 64'hF000_0000_0000_0000);
        exp_l1d(50'h801, 64'h0000_0000_0000_000F);
        exp_resp(64'h8877_6655_4433_2211, 8'h22, 1'b0, 5);
        send(3'd3, 56'h2003C, 8'h22);
        wait_done();

        // LHU at last byte
        set_byte(50'hC00, 63, 8'hFF);
        set_byte(50'hC01, 0, 8'h80);
        exp_l1d(50'hC00, 64'h8000_0000_0000_0000);
        exp_l1d(50'hC01, 64'h0000_0000_0000_0001);
        exp_resp(64'h0000_0000_0000_80FF, 8'h33, 1'b0, 5);
        send(3'd5, 56'h3003F, 8'h33);
        wait_done();

        // LB signed, mid line
        set_byte(50'h1000, 16, 8'h9A);
        exp_l1d(50'h1000, 64'h0000_0000_0001_0000);
        exp_resp(64'hFFFF_FFFF_FFFF_FF9A, 8'h44, 1'b0, 3);
        send(3'd0, 56'h40010, 8'h44);
        wait_done();

        // LH signed split
        set_byte(50'h1100, 63, 8'hFF);
        set_byte(50'h1101, 0, 8'h80);
        exp_l1d(50'h1100, 64'h8000_0000_0000_0000);
        exp_l1d(50'h1101, 64'h0000_0000_0000_0001);
        exp_resp(64'hFFFF_FFFF_FFFF_80FF, 8'h55, 1'b0, 5);
        send(3'd1, 56'h4403F, 8'h55);
        wait_done();

        // LWU split 2+2, with a neighbouring byte that must not leak in
        set_byte(50'h1200, 62, 8'hAA); set_byte(50'h1200, 63, 8'hBB);
        set_byte(50'h1201, 0, 8'hCC);  set_byte(50'h1201, 1, 8'hDD);
        set_byte(50'h1201, 2, 8'hEE);
        exp_l1d(50'h1200, 64'hC000_0000_0000_0000);
        exp_l1d(50'h1201, 64'h0000_0000_0000_0003);
        exp_resp(64'h0000_0000_DDCC_BBAA, 8'h66, 1'b0, 5);
        send(3'd6, 56'h4803E, 8'h66);
        wait_done();

        // LD ending exactly at the line end stays single
        for (int i = 0; i < 8; i++) set_byte(50'h1300, 56 + i, 8'(8'hF1 + i));
        set_byte(50'h1300, 55, 8'h12);
        exp_l1d(50'h1300, 64'hFF00_0000_0000_0000);
        exp_resp(64'hF8F7_F6F5_F4F3_F2F1, 8'h77, 1'b0, 3);
        send(3'd3, 56'h4C038, 8'h77);
        wait_done();

        // Split at the top of the address space wraps to line 0
        set_byte(50'h3_FFFF_FFFF_FFFF, 60, 8'h01); set_byte(50'h3_FFFF_FFFF_FFFF, 61, 8'h02);
        set_byte(50'h3_FFFF_FFFF_FFFF, 62, 8'h03); set_byte(50'h3_FFFF_FFFF_FFFF, 63, 8'h84);
        set_byte(50'h0, 0, 8'h05); set_byte(50'h0, 1, 8'h06);
        set_byte(50'h0, 2, 8'h07); set_byte(50'h0, 3, 8'h08);
        exp_l1d(50'h3_FFFF_FFFF_FFFF, 64'hF000_0000_0000_0000);
        exp_l1d(50'h0, 64'h0000_0000_0000_000F);
        exp_resp(64'h0807_0605_8403_0201, 8'h88, 1'b0, 5);
        send(3'd3, 56'hFF_FFFF_FFFF_FFFC, 8'h88);
        wait_done();

        // Reserved op with result held off
        @(posedge clk);
        #1 bus.ld_resp_rdy_i = 1'b0;
        exp_resp(64'h0, 8'h99, 1'b1, 1);
        send(3'd7, 56'h1234, 8'h99);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_vld", 64'(bus.ld_resp_vld_o), 64'd1);
            chk("hold_data", bus.ld_resp_data_o, 64'd0);
            chk("hold_err", 64'(bus.ld_resp_err_o), 64'd1);
            chk("hold_tag", 64'(bus.ld_resp_tag_o), 64'h99);
        end
        @(posedge clk);
        #1 bus.ld_resp_rdy_i = 1'b1;
        wait_done();

        // L1D stall: request must stay put
        @(posedge clk);
        #1 bus.l1d_req_rdy_i = 1'b0;
        set_byte(50'h1400, 63, 8'hE5);
        exp_l1d(50'h1400, 64'h8000_0000_0000_0000);
        exp_resp(64'h0000_0000_0000_00E5, 8'hAA, 1'b0, -1);
        send(3'd4, 56'h5003F, 8'hAA);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_vld", 64'(bus.l1d_req_vld_o), 64'd1);
            chk("stall_line", 64'(bus.l1d_req_line_o), 64'h1400);
            chk("stall_mask", bus.l1d_req_mask_o, 64'h8000_0000_0000_0000);
        end
        @(posedge clk);
        #1 bus.l1d_req_rdy_i = 1'b1;
        wait_done();

        // Flush while waiting for data: drain the late response, no result
        resp_dly = 3;
        exp_l1d(50'h1500, 64'h0000_0000_0000_00F0);
        send(3'd2, 56'h54004, 8'hBB);
        hs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.l1d_req_vld_o && bus.l1d_req_rdy_i) begin
                hs = 1;
                break;
            end
        end
        if (!hs) fail_evt("flush_l1d_handshake_timeout");
        @(posedge clk);
        #1 bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        @(negedge clk);
        chk("drain_rdy_a", 64'(bus.ld_req_rdy_o), 64'd0);
        chk("drain_resp_a", 64'(bus.ld_resp_vld_o), 64'd0);
        @(negedge clk);
        chk("drain_rdy_b", 64'(bus.ld_req_rdy_o), 64'd0);
        @(negedge clk);
        chk("drain_rdy_back", 64'(bus.ld_req_rdy_o), 64'd1);
        chk("drain_resp_c", 64'(bus.ld_resp_vld_o), 64'd0);
        resp_dly = 1;
        wait_done();
        exp_l1d(50'h40, 64'h0000_0000_0000_00F0);
        exp_resp(64'hFFFF_FFFF_8000_0000, 8'hCC, 1'b0, 3);
        send(3'd2, 56'h1004, 8'hCC);
        wait_done();

        // Flush while the line request is stalled
        @(posedge clk);
        #1 bus.l1d_req_rdy_i = 1'b0;
        send(3'd3, 56'h2003C, 8'hDD);
        #1 bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        @(negedge clk);
        chk("flush_req_l1d_vld", 64'(bus.l1d_req_vld_o), 64'd0);
        chk("flush_req_rdy", 64'(bus.ld_req_rdy_o), 64'd1);
        @(posedge clk);
        #1 bus.l1d_req_rdy_i = 1'b1;
        wait_done();

        // Asynchronous reset mid-operation
        @(posedge clk);
        #1 bus.l1d_req_rdy_i = 1'b0;
        send(3'd3, 56'h2003C, 8'hDE);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_req_rdy", 64'(bus.ld_req_rdy_o), 64'd1);
        chk("arst_l1d_vld", 64'(bus.l1d_req_vld_o), 64'd0);
        chk("arst_mask", bus.l1d_req_mask_o, 64'd0);
        chk("arst_line", 64'(bus.l1d_req_line_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.l1d_req_rdy_i = 1'b1;
        exp_l1d(50'h40, 64'h0000_0000_0000_00F0);
        exp_resp(64'hFFFF_FFFF_8000_0000, 8'hEE, 1'b0, 3);
        send(3'd2, 56'h1004, 8'hEE);
        wait_done();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
